adc_imi_mc: RTL and testbench
=============================

# adc_imi_mc

Parametrised multi-channel ADC imitator for bench and in-system bring-up of the MBO53 acquisition path, clocked from the 100 MHz domain. It reproduces the serial-ADC frame (CS window and data strobe) and round-robins over CH_NUM virtual channels. Each channel keeps its own waveform state: triangle, sawtooth, or hold, with a programmable step size. It sits in place of the real ADC front-end and feeds the same downstream consumers through adc_data / valid / ch_idx.

## Interface
- DATA_W, 16: sample width.
- CH_NUM, 4: number of virtual channels (1..16).
- FRAME_LEN, 19: cycles per conversion frame (counter 0..FRAME_LEN-1).
- STROBE_CYC, 13: frame cycle at which the sample is updated.
- CS_CYC, 14: first frame cycle with CS high; CS stays high through FRAME_LEN-1.
- LIM_LO, 2 / LIM_HI, 4090: waveform limits, LIM_LO < LIM_HI <= 2^DATA_W-1.
- PHASE_STEP, 100: start-value offset between adjacent channels.
- clk_100  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run enable; low = idle and re-initialise.
- mode  in  2  00 triangle, 01 sawtooth, 10 hold, 11 treated as triangle.
- step  in  8  increment per update, zero-extended to DATA_W+1.
- CS  out  1  chip-select imitation.
- valid  out  1  one-cycle sample strobe.
- ch_idx  out  4  channel of the current adc_data.
- adc_data  out  DATA_W  sample value.

## Operation
- Per channel k: value[k] (DATA_W bits) and dir[k] (1 = up). The init value is LIM_LO + k*PHASE_STEP, clipped to LIM_HI; init dir is 1.
- Frame counter cnt runs only while start=1 and wraps FRAME_LEN-1 -> 0. Channel pointer cur advances at the wrap and wraps CH_NUM-1 -> 0.
- mode and step are latched at cnt==0 into mode_q / step_q; changes mid-frame take effect at the next frame.
- At cnt==STROBE_CYC, channel cur updates. All arithmetic is in DATA_W+1 bits, so it never overflows.
  - Triangle, dir=1: if value+step >= LIM_HI, then value = LIM_HI and dir = 0; otherwise value += step.
  - Triangle, dir=0: if value <= LIM_LO+step, then value = LIM_LO and dir = 1; otherwise value -= step.
  - Sawtooth: if value+step > LIM_HI, then value = LIM_LO; otherwise value += step. dir is ignored and not changed.
  - Hold: value is unchanged.
  - step=0: value is unchanged in every mode, and no direction flip occurs.
- The updated value is registered to adc_data, cur to ch_idx, and valid pulses.
- Switching mode keeps value/dir, so there is no jump.
- start=0, or reset=1:
  - cnt=0, cur=0, CS=0, valid=0.
  - adc_data=0, ch_idx=0.
  - All channels return to their init value/dir.
  - Dropping start mid-frame aborts the frame with no valid.

## Timing
- All outputs are registered. Reset values: CS=0, valid=0, ch_idx=0, adc_data=0.
- start sampled high at edge E0 means cnt=1 after E0.
- valid rises after edge E0+STROBE_CYC (cnt==13 observed) and lasts exactly 1 cycle. With defaults, the first valid comes 14 cycles after start is sampled.
- adc_data/ch_idx hold until the next strobe.
- CS is high in the cycles where cnt is in CS_CYC..FRAME_LEN-1, i.e. 5 of every 19 cycles with defaults.
- Sample rate per channel: one per FRAME_LEN*CH_NUM cycles.
- reset has priority over start. Simultaneous reset and strobe: reset wins.

## Configuration
- ADC_IMI_MC_NOISE_EN defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset/idle) steps once per strobe. Its 3 LSBs are XORed into adc_data[2:0] on output only; stored value[k] is unaffected.
- Not defined: no LFSR, and adc_data equals value[k] exactly.

## Structure
- Shared package adc_imi_pkg holds:
  - mode encodings MODE_TRI/MODE_SAW/MODE_HOLD;
  - the LFSR polynomial/seed constants;
  - a helper function computing the next (value, dir) from (value, dir, step, mode, limits).
- One sub-module is natural: adc_imi_lfsr, instantiated only under ADC_IMI_MC_NOISE_EN.
- Channel state is held as arrays indexed by cur; there is no per-channel instance.

## Test plan
- reset high for 3 cycles with start=1 -> CS=0, valid=0, adc_data=0, ch_idx=0 throughout.
- Defaults, CH_NUM=2, mode=00, step=1, start rises -> valid 14 cycles later with ch_idx=0, adc_data=3. The next valid follows 19 cycles later with ch_idx=1, adc_data=103. CS is high for 5 cycles per frame.
- Triangle turnaround, step=5, ch0 at 4088 -> outputs 4090, then 4085 on ch0's next slot. Near the low limit, 6 -> 2 and dir flips.
- Sawtooth, step=5, ch0 at 4088 -> outputs 2. At 4085 -> outputs 4090, no wrap.
- mode changed to 10 at cnt=5 -> the current frame still applies the old mode; from the next frame, values stay constant per channel.
- start dropped at cnt=10 -> no valid that frame. On restart, ch0 resumes from init (first sample 3 with step=1).

Source files
------------

// File: rtl/adc_imi_pkg.sv
// Shared definitions for the multi-channel ADC imitator: mode encodings,
// noise LFSR constants and the per-channel waveform step function.
package adc_imi_pkg;

  typedef enum logic [1:0] {
    MODE_TRI  = 2'b00,
    MODE_SAW  = 2'b01,
    MODE_HOLD = 2'b10
  } mode_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // 32-bit working width covers DATA_W+1 for any sample width up to 31 bits,
  // so the add/compare below can never overflow.
  typedef struct packed {
    logic [31:0] value;
    logic        dir;    // 1 = counting up
  } chan_state_t;

  // Next (value, dir) of one channel for a single strobe.
  function automatic chan_state_t next_chan(input chan_state_t cur,
                                            input logic [31:0]  step,
                                            input logic [1:0]   mode,
                                            input logic [31:0]  lim_lo,
                                            input logic [31:0]  lim_hi);
    chan_state_t nxt;
    nxt = cur;
    if (step != 32'd0) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SAW: begin
          if (cur.value + step > lim_hi) nxt.value = lim_lo;
          else                           nxt.value = cur.value + step;
        end
        default: begin  // triangle, including the unused 2'b11 code
          if (cur.dir) begin
            if (cur.value + step >= lim_hi) begin
              nxt.value = lim_hi;
              nxt.dir   = 1'b0;
            end else begin
              nxt.value = cur.value + step;
            end
          end else begin
            if (cur.value <= lim_lo + step) begin
              nxt.value = lim_lo;
              nxt.dir   = 1'b1;
            end else begin
              nxt.value = cur.value - step;
            end
          end
        end
      endcase
    end
    return nxt;
  endfunction

  // Start value of channel k: phase-shifted from the low limit, clipped high.
  function automatic logic [31:0] init_value(input int unsigned k,
                                             input int unsigned lim_lo,
                                             input int unsigned lim_hi,
                                             input int unsigned phase);
    logic [31:0] v;
    v = lim_lo + k * phase;
    return (v > lim_hi) ? lim_hi : v;
  endfunction

endpackage

// File: rtl/adc_imi_lfsr.sv
// Noise source for the ADC imitator: 16-bit Galois LFSR stepped once per
// sample strobe, reseeded on reset and while the imitator is idle.
module adc_imi_lfsr
  import adc_imi_pkg::*;
(
  input  logic       clk_100,
  input  logic       reset,
  input  logic       clear,
  input  logic       step_en,
  output logic [2:0] noise
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next LFSR state: reseed when idle, shift on each strobe.
  always_comb begin
    lfsr_d = lfsr_q;
    if (clear) begin
      lfsr_d = LFSR_SEED;
    end else if (step_en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_100) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign noise = lfsr_q[2:0];

endmodule

// File: rtl/adc_imi_mc.sv
// Multi-channel serial-ADC imitator. Generates the frame timing (CS window,
// sample strobe) and round-robins CH_NUM channels, each running its own
// triangle / sawtooth / hold waveform.
// Optional build macro ADC_IMI_MC_NOISE_EN adds LFSR noise on adc_data[2:0].
module adc_imi_mc
  import adc_imi_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned FRAME_LEN  = 19,
  parameter int unsigned STROBE_CYC = 13,
  parameter int unsigned CS_CYC     = 14,
  parameter int unsigned LIM_LO     = 2,
  parameter int unsigned LIM_HI     = 4090,
  parameter int unsigned PHASE_STEP = 100
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        step,
  output logic              CS,
  output logic              valid,
  output logic [3:0]        ch_idx,
  output logic [DATA_W-1:0] adc_data
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] STROBE_AT = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] CS_FIRST  = CNT_W'(CS_CYC);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH_NUM - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        step_q, step_d;
  logic [DATA_W-1:0] value_q [CH_NUM];
  logic [DATA_W-1:0] value_d [CH_NUM];
  logic [CH_NUM-1:0] dir_q, dir_d;
  logic              cs_q, cs_d;
  logic              valid_q, valid_d;
  logic [3:0]        ch_idx_q, ch_idx_d;
  logic [DATA_W-1:0] adc_data_q, adc_data_d;

  logic              strobe;
  logic [DATA_W-1:0] noise;
  chan_state_t       cur_st, upd;

  assign strobe = start && (cnt_q == STROBE_AT);

`ifdef ADC_IMI_MC_NOISE_EN
  logic [2:0] lfsr_bits;

  adc_imi_lfsr u_lfsr (
    .clk_100 (clk_100),
    .reset   (reset),
    .clear   (!start),
    .step_en (strobe),
    .noise   (lfsr_bits)
  );

  assign noise = DATA_W'(lfsr_bits);
`else
  assign noise = '0;
`endif

  // Frame sequencing, per-channel waveform update and output staging.
  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    mode_d     = mode_q;
    step_d     = step_q;
    value_d    = value_q;
    dir_d      = dir_q;
    cs_d       = 1'b0;
    valid_d    = 1'b0;
    ch_idx_d   = ch_idx_q;
    adc_data_d = adc_data_q;

    cur_st.value = 32'(value_q[cur_q]);
    cur_st.dir   = dir_q[cur_q];
    upd          = next_chan(cur_st, 32'(step_q), mode_q, LIM_LO, LIM_HI);

    if (!start) begin
      // Idle: abort any frame and put every channel back at its start point.
      cnt_d      = '0;
      cur_d      = '0;
      ch_idx_d   = '0;
      adc_data_d = '0;
      for (int k = 0; k < CH_NUM; k++) begin
        value_d[k] = DATA_W'(init_value(k, LIM_LO, LIM_HI, PHASE_STEP));
        dir_d[k]   = 1'b1;
      end
    end else begin
      // Mode/step are frame-stable: sampled only on the first frame cycle.
      if (cnt_q == '0) begin
        mode_d = mode;
        step_d = step;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        cur_d = (cur_q == CH_LAST) ? '0 : cur_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (strobe) begin
        value_d[cur_q] = DATA_W'(upd.value);
        dir_d[cur_q]   = upd.dir;
        valid_d        = 1'b1;
        ch_idx_d       = 4'(cur_q);
        adc_data_d     = DATA_W'(upd.value) ^ noise;
      end
      // CS is registered from the next count so it lines up with cnt itself.
      cs_d = (cnt_d >= CS_FIRST);
    end
  end

  // State and output registers; reset restores the channel start points.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      mode_q     <= '0;
      step_q     <= '0;
      cs_q       <= 1'b0;
      valid_q    <= 1'b0;
      ch_idx_q   <= '0;
      adc_data_q <= '0;
      dir_q      <= '1;
      // NOTE: this channel array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int k = 0; k < CH_NUM; k++) begin
        value_q[k] <= DATA_W'(init_value(k, LIM_LO, LIM_HI, PHASE_STEP));
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      value_q    <= value_d;
      dir_q      <= dir_d;
      cs_q       <= cs_d;
      valid_q    <= valid_d;
      ch_idx_q   <= ch_idx_d;
      adc_data_q <= adc_data_d;
    end
  end

  assign CS       = cs_q;
  assign valid    = valid_q;
  assign ch_idx   = ch_idx_q;
  assign adc_data = adc_data_q;

endmodule

// File: tb/tb_adc_imi_mc.sv
// Self-checking bench for adc_imi_mc (two channels, default frame timing).
// A behavioural channel model pushes the expected sample of each frame into
// a scoreboard queue; it is popped and compared when valid is observed.
module tb_adc_imi_mc;

  localparam int DATA_W     = 16;
  localparam int CH_NUM     = 2;
  localparam int FRAME_LEN  = 19;
  localparam int STROBE_CYC = 13;
  localparam int CS_CYC     = 14;
  localparam int LIM_LO     = 2;
  localparam int LIM_HI     = 4090;
  localparam int PHASE      = 100;

  logic              clk_100 = 1'b0;
  logic              reset   = 1'b1;
  logic              start   = 1'b0;
  logic [1:0]        mode    = 2'b00;
  logic [7:0]        step    = 8'd0;
  logic              cs;
  logic              valid;
  logic [3:0]        ch_idx;
  logic [DATA_W-1:0] adc_data;

  always #5 clk_100 = ~clk_100;

  adc_imi_mc #(
    .DATA_W     (DATA_W),
    .CH_NUM     (CH_NUM),
    .FRAME_LEN  (FRAME_LEN),
    .STROBE_CYC (STROBE_CYC),
    .CS_CYC     (CS_CYC),
    .LIM_LO     (LIM_LO),
    .LIM_HI     (LIM_HI),
    .PHASE_STEP (PHASE)
  ) dut (
    .clk_100  (clk_100),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .step     (step),
    .CS       (cs),
    .valid    (valid),
    .ch_idx   (ch_idx),
    .adc_data (adc_data)
  );

  typedef struct {
    logic [3:0]        ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference channel model
  int   mv   [CH_NUM];
  bit   mdir [CH_NUM];
  int   mcur;

  task automatic model_reset();
    for (int k = 0; k < CH_NUM; k++) begin
      mv[k]   = (LIM_LO + k * PHASE > LIM_HI) ? LIM_HI : LIM_LO + k * PHASE;
      mdir[k] = 1'b1;
    end
    mcur = 0;
  endtask

  task automatic model_frame(input logic [1:0] md, input int st);
    int   v;
    bit   d;
    exp_t e;
    v = mv[mcur];
    d = mdir[mcur];
    if (st != 0) begin
      if (md == 2'b01) begin
        v = (v + st > LIM_HI) ? LIM_LO : v + st;
      end else if (md != 2'b10) begin
        if (d) begin
          if (v + st >= LIM_HI) begin v = LIM_HI; d = 1'b0; end
          else v = v + st;
        end else begin
          if (v <= LIM_LO + st) begin v = LIM_LO; d = 1'b1; end
          else v = v - st;
        end
      end
    end
    mv[mcur]   = v;
    mdir[mcur] = d;
    e.ch   = 4'(mcur);
    e.data = DATA_W'(v);
    sb.push_back(e);
    mcur = (mcur + 1) % CH_NUM;
  endtask

  // One 19-cycle frame. mid_at / abort_at name the cnt value at which mode is
  // changed or start is dropped (-1 = never).
  task automatic run_frame(input logic [1:0] md, input logic [7:0] st,
                           input int mid_at, input logic [1:0] mid_md,
                           input int abort_at);
    int   valid_cnt = 0;
    int   valid_pos = -1;
    int   cs_cnt    = 0;
    exp_t e;
    start = 1'b1;
    mode  = md;
    step  = st;
    if (abort_at < 0) model_frame(md, int'(st));
    for (int j = 0; j < FRAME_LEN; j++) begin
      @(posedge clk_100); #1;
      if (valid === 1'b1) begin
        valid_cnt++;
        valid_pos = j;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: ch_idx=%0d adc_data=%0d, no sample expected", ch_idx, adc_data);
        end else begin
          e = sb.pop_front();
          if (ch_idx !== e.ch) begin
            miscompares++;
            $display("FAIL ch_idx: got %0d, want %0d", ch_idx, e.ch);
          end
          vectors++;
          if (adc_data !== e.data) begin
            miscompares++;
            $display("FAIL adc_data ch%0d: got %0d, want %0d", e.ch, adc_data, e.data);
          end
        end
      end
      if (cs === 1'b1) cs_cnt++;
      if (j + 1 == mid_at)   mode  = mid_md;
      if (j + 1 == abort_at) start = 1'b0;
    end
    if (abort_at >= 0) begin
      vectors++;
      if (valid_cnt != 0) begin
        miscompares++;
        $display("FAIL aborted_frame_valids: got %0d, want 0", valid_cnt);
      end
      model_reset();
    end else begin
      vectors++;
      if (valid_cnt != 1) begin
        miscompares++;
        $display("FAIL valids_per_frame: got %0d, want 1", valid_cnt);
      end
      vectors++;
      if (valid_pos != STROBE_CYC) begin
        miscompares++;
        $display("FAIL valid_position: got edge %0d, want edge %0d", valid_pos, STROBE_CYC);
      end
      vectors++;
      if (cs_cnt != FRAME_LEN - CS_CYC) begin
        miscompares++;
        $display("FAIL cs_cycles: got %0d, want %0d", cs_cnt, FRAME_LEN - CS_CYC);
      end
    end
  endtask

  task automatic std_frame(input logic [1:0] md, input logic [7:0] st);
    run_frame(md, st, -1, 2'b00, -1);
  endtask

  // Channel 0 frame with the given step, then a channel 1 frame holding still.
  task automatic ch0_frame(input logic [1:0] md, input logic [7:0] st);
    std_frame(md, st);
    std_frame(md, 8'd0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100); #1;
      vectors++;
      if ({cs, valid, ch_idx, adc_data} !== '0) begin
        miscompares++;
        $display("FAIL idle_outputs: CS=%b valid=%b ch_idx=%0d adc_data=%0d, want all 0", cs, valid, ch_idx, adc_data);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d samples never seen, want 0", sb.size());
    end
    sb.delete();
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    mode  = 2'b00;
    step  = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_100); #1;
      vectors++;
      if ({cs, valid, ch_idx, adc_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: CS=%b valid=%b ch_idx=%0d adc_data=%0d, want all 0", cs, valid, ch_idx, adc_data);
      end
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    std_frame(2'b00, 8'd1);  // ch0 2 -> 3
    std_frame(2'b00, 8'd1);  // ch1 102 -> 103
    std_frame(2'b11, 8'd1);  // ch0 3 -> 4, code 11 behaves as triangle
    std_frame(2'b00, 8'd0);  // ch1 stays 103 with step 0
    idle(2);
  endtask

  task automatic test_triangle();
    for (int i = 0; i < 16; i++) ch0_frame(2'b00, 8'd255);  // ch0 -> 4082
    ch0_frame(2'b00, 8'd6);                                 // 4088
    ch0_frame(2'b00, 8'd5);                                 // clamp 4090, turn down
    ch0_frame(2'b00, 8'd5);                                 // 4085
    for (int i = 0; i < 15; i++) ch0_frame(2'b00, 8'd255);  // 260
    ch0_frame(2'b00, 8'd254);                               // 6
    ch0_frame(2'b00, 8'd5);                                 // clamp 2, turn up
    ch0_frame(2'b00, 8'd5);                                 // 7
    idle(2);
  endtask

  task automatic test_sawtooth();
    for (int i = 0; i < 16; i++) ch0_frame(2'b00, 8'd255);
    ch0_frame(2'b00, 8'd6);                                 // 4088
    ch0_frame(2'b01, 8'd5);                                 // wrap to 2
    for (int i = 0; i < 16; i++) ch0_frame(2'b01, 8'd255);  // 4082
    ch0_frame(2'b01, 8'd3);                                 // 4085
    ch0_frame(2'b01, 8'd5);                                 // 4090, no wrap
    ch0_frame(2'b01, 8'd5);                                 // wrap to 2
    idle(2);
  endtask

  task automatic test_mode_change();
    run_frame(2'b00, 8'd1, 5, 2'b10, -1);  // old mode still used: ch0 3
    std_frame(2'b10, 8'd1);                // ch1 held at 102
    std_frame(2'b10, 8'd1);                // ch0 held at 3
    std_frame(2'b10, 8'd1);                // ch1 held at 102
    idle(2);
  endtask

  task automatic test_abort();
    std_frame(2'b00, 8'd1);                // ch0 3
    std_frame(2'b00, 8'd1);                // ch1 103
    run_frame(2'b00, 8'd1, -1, 2'b00, 10); // dropped at cnt=10
    idle(3);
    std_frame(2'b00, 8'd1);                // ch0 restarts: 3
    std_frame(2'b00, 8'd1);                // ch1 restarts: 103
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_triangle();
    test_sawtooth();
    test_mode_change();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
